// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise logic pipe: op codes, mode values, REDUCE FSM states.
package bitwise_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic MODE_PAIR   = 1'b0;
    localparam logic MODE_REDUCE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational N-bit bitwise operator: y = a OP b.
module bitwise_op_core
    import bitwise_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Decode the op code into one of the eight bitwise functions.
    always_comb begin
        y = a;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_ANDN: y = a & ~b;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Streaming bitwise logic unit: PAIR mode (i0 OP i1 per beat) and REDUCE mode (fold i0 over a
// first..last frame), valid/ready in, registered output stage.
// Optional feature macro: BITWISE_PARITY_EN adds out_parity and out_zero.
module bitwise_logic_pipe
    import bitwise_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [N-1:0]     i0,
    input  logic [N-1:0]     i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
`ifdef BITWISE_PARITY_EN
    output logic             out_parity,
    output logic             out_zero,
`endif
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             frame_err_q, frame_err_d;
`ifdef BITWISE_PARITY_EN
    logic             out_parity_q, out_parity_d;
    logic             out_zero_q, out_zero_d;
`endif

    logic [N-1:0]     pair_y;
    logic [N-1:0]     fold_y;
    logic             accept;
    logic             restart;
    logic [N-1:0]     acc_new;
    logic [CNT_W-1:0] beats_new;

    bitwise_op_core #(.N(N)) u_pair_core (
        .op (in_op),
        .a  (i0),
        .b  (i1),
        .y  (pair_y)
    );

    bitwise_op_core #(.N(N)) u_fold_core (
        .op (in_op),
        .a  (acc_q),
        .b  (i0),
        .y  (fold_y)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Value the accumulator takes on a REDUCE beat; a beat in IDLE or a new first starts over.
    always_comb begin
        restart   = (state_q == ST_IDLE) || in_first;
        acc_new   = restart ? i0 : fold_y;
        beats_new = CntOne;
        if (!restart) begin
            beats_new = (beats_q == CntMax) ? CntMax : beats_q + CntOne;
        end
    end

    // REDUCE FSM next state and output-stage load decisions.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        frame_err_d = 1'b0;

        // A pending result leaves once downstream takes it; a new load below overrides.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_mode == MODE_PAIR) begin
                out_valid_d = 1'b1;
                out_data_d  = pair_y;
                out_count_d = CntOne;
            end else begin
                acc_d       = acc_new;
                beats_d     = beats_new;
                frame_err_d = (state_q == ST_ACCUM) && in_first;
                if (in_last) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_new;
                    out_count_d = beats_new;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
        end
    end

`ifdef BITWISE_PARITY_EN
    // Status flags track whatever out_data is loaded with.
    always_comb begin
        out_parity_d = out_parity_q;
        out_zero_d   = out_zero_q;
        if (accept && ((in_mode == MODE_PAIR) || in_last)) begin
            out_parity_d = ^out_data_d;
            out_zero_d   = (out_data_d == '0);
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            beats_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            frame_err_q  <= 1'b0;
`ifdef BITWISE_PARITY_EN
            out_parity_q <= 1'b0;
            out_zero_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beats_q      <= beats_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            frame_err_q  <= frame_err_d;
`ifdef BITWISE_PARITY_EN
            out_parity_q <= out_parity_d;
            out_zero_q   <= out_zero_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign frame_err  = frame_err_q;
`ifdef BITWISE_PARITY_EN
    assign out_parity = out_parity_q;
    assign out_zero   = out_zero_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: driver pushes expected results, monitor pops them.
module tb_bitwise_logic_pipe;

    localparam int N     = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_mode;
    logic             in_first;
    logic             in_last;
    logic [N-1:0]     i0;
    logic [N-1:0]     i1;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [CNT_W-1:0] out_count;
    logic             frame_err;
`ifdef BITWISE_PARITY_EN
    logic             out_parity;
    logic             out_zero;
`endif

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_mode   (in_mode),
        .in_first  (in_first),
        .in_last   (in_last),
        .i0        (i0),
        .i1        (i1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
`ifdef BITWISE_PARITY_EN
        .out_parity(out_parity),
        .out_zero  (out_zero),
`endif
        .frame_err (frame_err)
    );

    typedef struct packed {
        logic [N-1:0]     data;
        logic [CNT_W-1:0] count;
        logic             parity;
        logic             zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a result transfers at the next posedge when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data %0h with nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                popped++;
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_count", 64'(out_count), 64'(e.count));
`ifdef BITWISE_PARITY_EN
                check("out_parity", 64'(out_parity), 64'(e.parity));
                check("out_zero", 64'(out_zero), 64'(e.zero));
`endif
            end
        end
    end

    // Drive one beat; when exp_en, push the hand-computed result it should produce.
    task automatic send(input logic [2:0] op, input logic mode, input logic first,
                        input logic last, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic exp_en, input logic [N-1:0] ed, input logic [CNT_W-1:0] ec);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_mode  = mode;
        in_first = first;
        in_last  = last;
        i0       = a;
        i1       = b;
        if (exp_en) begin
            e.data   = ed;
            e.count  = ec;
            e.parity = ^ed;
            e.zero   = (ed == '0);
            exp_q.push_back(e);
            pushed++;
        end
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_mode   = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        i0        = '0;
        i1        = '0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // PAIR: XOR first, then every op back-to-back on the same operands.
        send(3'b010, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'hCF075530, 8'd1);
        @(negedge clk);
        check("pair_xor_latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        send(3'b000, 1'b0, 1'b1, 1'b1, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h1008A083, 8'd1);
        send(3'b001, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'hDF0FF5B3, 8'd1);
        send(3'b011, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h30F8AACF, 8'd1);
        send(3'b100, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'hEFF75F7C, 8'd1);
        send(3'b101, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h20F00A4C, 8'd1);
        send(3'b110, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h4F015020, 8'd1);
        send(3'b111, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h5F09F0A3, 8'd1);
        idle(2);

        // REDUCE XOR frame of three beats.
        send(3'b010, 1'b1, 1'b1, 1'b0, 32'hFFFF0000, 32'h0, 1'b0, '0, '0);
        send(3'b010, 1'b1, 1'b0, 1'b0, 32'h0F0F0F0F, 32'h0, 1'b0, '0, '0);
        send(3'b010, 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h0, 1'b1, 32'hF0F00F0E, 8'd3);
        idle(2);

        // Mixed ops within a frame: OR then AND.
        send(3'b111, 1'b1, 1'b1, 1'b0, 32'hF0F0F0F0, 32'h0, 1'b0, '0, '0);
        send(3'b001, 1'b1, 1'b0, 1'b0, 32'h0F000000, 32'h0, 1'b0, '0, '0);
        send(3'b000, 1'b1, 1'b0, 1'b1, 32'h00FFFF00, 32'h0, 1'b1, 32'h00F0F000, 8'd3);
        // Single-beat frame.
        send(3'b010, 1'b1, 1'b1, 1'b1, 32'h13579BDF, 32'h0, 1'b1, 32'h13579BDF, 8'd1);
        idle(2);

        // Stall: result must hold and input must be blocked.
        out_ready = 1'b0;
        send(3'b010, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'hCF075530, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", 64'(out_data), 64'hCF075530);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'b000, 1'b0, 1'b0, 1'b0, 32'h5F09F0A3, 32'h900EA593, 1'b1, 32'h1008A083, 8'd1);
        idle(2);

        // Restart inside an open frame raises frame_err for one cycle.
        send(3'b010, 1'b1, 1'b1, 1'b0, 32'h12345678, 32'h0, 1'b0, '0, '0);
        send(3'b010, 1'b1, 1'b1, 1'b0, 32'hAAAA0000, 32'h0, 1'b0, '0, '0);
        check("frame_err_pulse", 64'(frame_err), 64'd1);
        idle(1);
        check("frame_err_clear", 64'(frame_err), 64'd0);
        send(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000AAAA, 32'h0, 1'b1, 32'hAAAAAAAA, 8'd2);
        idle(2);

        // Saturation: 300 beats of 1 XORed -> data 0, count pinned at 255.
        send(3'b010, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0, '0, '0);
        for (int k = 0; k < 298; k++) begin
            send(3'b010, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 1'b0, '0, '0);
        end
        send(3'b010, 1'b1, 1'b0, 1'b1, 32'h1, 32'h0, 1'b1, 32'h0, 8'd255);
        idle(2);

        // Reset mid-frame must return the FSM to IDLE.
        send(3'b010, 1'b1, 1'b1, 1'b0, 32'h11111111, 32'h0, 1'b0, '0, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_frame_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000BEEF, 32'h0, 1'b1, 32'h0000BEEF, 8'd1);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("results_seen", 64'(popped), 64'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
